// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALU operation classes, decode control bundle
// and the ID/EX latch layout used by decode_module and execute_module.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SLTI  = 6'h0A;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_SLT   = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        DEST_NONE = 2'd0,
        DEST_RT   = 2'd1,
        DEST_RD   = 2'd2
    } dest_e;

    typedef struct packed {
        logic    valid;
        alu_op_e alu_op;
        logic    alu_src;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch;
        logic    zero_ext;
        logic    uses_rt;
        dest_e   dest_sel;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] read_data_1;
        logic [31:0] read_data_2;
        logic [31:0] immediate;
        logic [5:0]  funct;
        alu_op_e     alu_op;
        logic        alu_src;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic        ex_valid;
        logic        illegal_instr;
    } idex_t;

    localparam ctrl_t CTRL_NONE   = '0;
    localparam idex_t IDEX_BUBBLE = '0;

    function automatic ctrl_t decode_opcode(input logic [5:0] op);
        ctrl_t c;
        c = CTRL_NONE;
        case (op)
            OP_RTYPE: begin
                c.valid = 1'b1; c.alu_op = ALU_FUNCT; c.reg_write = 1'b1;
                c.uses_rt = 1'b1; c.dest_sel = DEST_RD;
            end
            OP_LW: begin
                c.valid = 1'b1; c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.reg_write = 1'b1;
                c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.dest_sel = DEST_RT;
            end
            OP_SW: begin
                c.valid = 1'b1; c.alu_op = ALU_ADD; c.alu_src = 1'b1;
                c.mem_write = 1'b1; c.uses_rt = 1'b1;
            end
            OP_BEQ: begin
                c.valid = 1'b1; c.alu_op = ALU_SUB; c.branch = 1'b1; c.uses_rt = 1'b1;
            end
            OP_ADDI: begin
                c.valid = 1'b1; c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.reg_write = 1'b1;
                c.dest_sel = DEST_RT;
            end
            OP_ANDI: begin
                c.valid = 1'b1; c.alu_op = ALU_AND; c.alu_src = 1'b1; c.reg_write = 1'b1;
                c.zero_ext = 1'b1; c.dest_sel = DEST_RT;
            end
            OP_ORI: begin
                c.valid = 1'b1; c.alu_op = ALU_OR; c.alu_src = 1'b1; c.reg_write = 1'b1;
                c.zero_ext = 1'b1; c.dest_sel = DEST_RT;
            end
            OP_SLTI: begin
                c.valid = 1'b1; c.alu_op = ALU_SLT; c.alu_src = 1'b1; c.reg_write = 1'b1;
                c.dest_sel = DEST_RT;
            end
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one write port, r0 hardwired to 0.
// DECODE_WB_BYPASS_EN makes the read ports write-first against the write port.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr_1,
    input  logic [4:0]  raddr_2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_1,
    output logic [31:0] rdata_2
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Next-state of the storage: apply the write unless it targets r0.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != 5'd0)) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d = regs_q;
        end
    end

    // Storage flops, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports; r0 is forced to zero regardless of storage or bypass.
    always_comb begin
        rdata_1 = regs_q[raddr_1];
        rdata_2 = regs_q[raddr_2];
`ifdef DECODE_WB_BYPASS_EN
        if (we && (waddr == raddr_1)) begin
            rdata_1 = wdata;
        end else begin
            rdata_1 = regs_q[raddr_1];
        end
        if (we && (waddr == raddr_2)) begin
            rdata_2 = wdata;
        end else begin
            rdata_2 = regs_q[raddr_2];
        end
`else
`endif
        if (raddr_1 == 5'd0) begin
            rdata_1 = 32'd0;
        end else begin
            rdata_1 = rdata_1;
        end
        if (raddr_2 == 5'd0) begin
            rdata_2 = 32'd0;
        end else begin
            rdata_2 = rdata_2;
        end
    end

endmodule

// File: rtl/decode_module.sv
// MIPS instruction-decode stage: register read, control decode, immediate extension,
// load-use hazard detection and the ID/EX latch. Write-first bypass: DECODE_WB_BYPASS_EN.
module decode_module
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    input  logic        flush,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    output logic        stall,
    output logic [31:0] alu_read_data_1,
    output logic [31:0] alu_read_data_2,
    output logic [31:0] immediate,
    output logic [5:0]  funct,
    output logic [2:0]  alu_op,
    output logic        alu_src,
    output logic [4:0]  write_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        branch,
    output logic        ex_valid,
    output logic        illegal_instr
);

    logic [5:0]  opcode_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [31:0] rdata_1_s;
    logic [31:0] rdata_2_s;
    ctrl_t       ctrl_s;
    logic        hazard_s;
    idex_t       idex_d;
    idex_t       idex_q;

    assign opcode_s = instruction[31:26];
    assign rs_s     = instruction[25:21];
    assign rt_s     = instruction[20:16];
    assign rd_s     = instruction[15:11];
    assign ctrl_s   = decode_opcode(opcode_s);

    register_file u_register_file (
        .clk     (clk),
        .rst     (rst),
        .raddr_1 (rs_s),
        .raddr_2 (rt_s),
        .we      (wb_reg_write),
        .waddr   (wb_write_reg),
        .wdata   (wb_write_data),
        .rdata_1 (rdata_1_s),
        .rdata_2 (rdata_2_s)
    );

    // A load in EX whose destination feeds this instruction must wait one cycle.
    assign hazard_s = instr_valid & ~flush & idex_q.ex_valid & idex_q.mem_read
                    & (idex_q.write_reg != 5'd0)
                    & ((idex_q.write_reg == rs_s)
                       | (ctrl_s.uses_rt & (idex_q.write_reg == rt_s)));
    assign stall    = hazard_s;

    // ID/EX next state: flush, stall and bubbles all win over decode.
    always_comb begin
        idex_d = IDEX_BUBBLE;
        if (flush || hazard_s || !instr_valid) begin
            idex_d = IDEX_BUBBLE;
        end else if (!ctrl_s.valid) begin
            idex_d.illegal_instr = 1'b1;
        end else begin
            idex_d.read_data_1 = rdata_1_s;
            idex_d.read_data_2 = rdata_2_s;
            if (ctrl_s.zero_ext) begin
                idex_d.immediate = {16'd0, instruction[15:0]};
            end else begin
                idex_d.immediate = {{16{instruction[15]}}, instruction[15:0]};
            end
            idex_d.funct      = instruction[5:0];
            idex_d.alu_op     = ctrl_s.alu_op;
            idex_d.alu_src    = ctrl_s.alu_src;
            idex_d.reg_write  = ctrl_s.reg_write;
            idex_d.mem_read   = ctrl_s.mem_read;
            idex_d.mem_write  = ctrl_s.mem_write;
            idex_d.mem_to_reg = ctrl_s.mem_to_reg;
            idex_d.branch     = ctrl_s.branch;
            idex_d.ex_valid   = 1'b1;
            case (ctrl_s.dest_sel)
                DEST_RD: idex_d.write_reg = rd_s;
                DEST_RT: idex_d.write_reg = rt_s;
                default: idex_d.write_reg = 5'd0;
            endcase
        end
    end

    // ID/EX pipeline latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= IDEX_BUBBLE;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign alu_read_data_1 = idex_q.read_data_1;
    assign alu_read_data_2 = idex_q.read_data_2;
    assign immediate       = idex_q.immediate;
    assign funct           = idex_q.funct;
    assign alu_op          = idex_q.alu_op;
    assign alu_src         = idex_q.alu_src;
    assign write_reg       = idex_q.write_reg;
    assign reg_write       = idex_q.reg_write;
    assign mem_read        = idex_q.mem_read;
    assign mem_write       = idex_q.mem_write;
    assign mem_to_reg      = idex_q.mem_to_reg;
    assign branch          = idex_q.branch;
    assign ex_valid        = idex_q.ex_valid;
    assign illegal_instr   = idex_q.illegal_instr;

endmodule

// File: tb/tb_decode_module.sv
// Self-checking bench for decode_module: opcode-table model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_decode_module;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        flush;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        stall;
    logic [31:0] alu_read_data_1;
    logic [31:0] alu_read_data_2;
    logic [31:0] immediate;
    logic [5:0]  funct;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic [4:0]  write_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        ex_valid;
    logic        illegal_instr;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    decode_module dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .flush(flush), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .stall(stall),
        .alu_read_data_1(alu_read_data_1), .alu_read_data_2(alu_read_data_2),
        .immediate(immediate), .funct(funct), .alu_op(alu_op), .alu_src(alu_src),
        .write_reg(write_reg), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch),
        .ex_valid(ex_valid), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    // Opcode table: supported, alu_op, alu_src, reg_write, mem_read(=mem_to_reg),
    // mem_write, branch, zero-extend, uses rt, destination (0 none, 1 rt, 2 rd)
    bit       t_ok  [64];
    bit [2:0] t_aop [64];
    bit       t_src [64];
    bit       t_rw  [64];
    bit       t_mr  [64];
    bit       t_mw  [64];
    bit       t_br  [64];
    bit       t_zx  [64];
    bit       t_urt [64];
    int       t_dst [64];

    task automatic set_op(input int op, input bit [2:0] aop, input bit src, input bit rw,
                          input bit mr, input bit mw, input bit br, input bit zx,
                          input bit urt, input int dst);
        t_ok[op] = 1'b1; t_aop[op] = aop; t_src[op] = src; t_rw[op] = rw; t_mr[op] = mr;
        t_mw[op] = mw; t_br[op] = br; t_zx[op] = zx; t_urt[op] = urt; t_dst[op] = dst;
    endtask

    // Model state: register contents and what ID/EX must hold
    logic [31:0] mregs [32];
    logic [31:0] e_rd1, e_rd2, e_imm;
    logic [5:0]  e_funct;
    logic [2:0]  e_aop;
    logic [4:0]  e_wreg;
    bit e_src, e_rw, e_mr, e_mw, e_m2r, e_br, e_v, e_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        int op;
        op = int'(instruction[31:26]);
        return instr_valid && !flush && e_v && e_mr && (e_wreg != 5'd0) &&
               ((e_wreg == instruction[25:21]) ||
                (t_urt[op] && (e_wreg == instruction[20:16])));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (BYP && wb_reg_write && (wb_write_reg == r)) return wb_write_data;
        return mregs[r];
    endfunction

    task automatic m_clear();
        e_rd1 = 32'd0; e_rd2 = 32'd0; e_imm = 32'd0; e_funct = 6'd0; e_aop = 3'd0;
        e_wreg = 5'd0; e_src = 1'b0; e_rw = 1'b0; e_mr = 1'b0; e_mw = 1'b0;
        e_m2r = 1'b0; e_br = 1'b0; e_v = 1'b0; e_ill = 1'b0;
    endtask

    // Reference model of the stage, advanced on each clock edge
    always @(posedge clk or posedge rst) begin
        bit          s;
        int          op;
        logic [31:0] n1, n2;
        if (rst) begin
            m_clear();
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else begin
            s  = m_stall();
            op = int'(instruction[31:26]);
            n1 = m_read(instruction[25:21]);
            n2 = m_read(instruction[20:16]);
            m_clear();
            if (!(flush || s || !instr_valid)) begin
                if (!t_ok[op]) begin
                    e_ill = 1'b1;
                end else begin
                    e_rd1 = n1; e_rd2 = n2;
                    e_imm = t_zx[op] ? {16'd0, instruction[15:0]}
                                     : 32'(signed'(instruction[15:0]));
                    e_funct = instruction[5:0]; e_aop = t_aop[op]; e_src = t_src[op];
                    e_rw = t_rw[op]; e_mr = t_mr[op]; e_m2r = t_mr[op]; e_mw = t_mw[op];
                    e_br = t_br[op]; e_v = 1'b1;
                    e_wreg = (t_dst[op] == 2) ? instruction[15:11] :
                             (t_dst[op] == 1) ? instruction[20:16] : 5'd0;
                end
            end
            if (wb_reg_write && (wb_write_reg != 5'd0)) mregs[wb_write_reg] = wb_write_data;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (run && !rst) begin
            chk("stall", {31'd0, stall}, {31'd0, m_stall()});
            chk("rd1", alu_read_data_1, e_rd1);
            chk("rd2", alu_read_data_2, e_rd2);
            chk("imm", immediate, e_imm);
            chk("funct", {26'd0, funct}, {26'd0, e_funct});
            chk("alu_op", {29'd0, alu_op}, {29'd0, e_aop});
            chk("write_reg", {27'd0, write_reg}, {27'd0, e_wreg});
            chk("ctrl", {24'd0, alu_src, reg_write, mem_read, mem_write, mem_to_reg,
                         branch, ex_valid, illegal_instr},
                        {24'd0, e_src, e_rw, e_mr, e_mw, e_m2r, e_br, e_v, e_ill});
        end
    end

    task automatic drive(input logic [31:0] ins, input bit v, input bit f);
        instruction = ins; instr_valid = v; flush = f;
        #1;
    endtask

    task automatic wb(input bit we, input logic [4:0] r, input logic [31:0] d);
        wb_reg_write = we; wb_write_reg = r; wb_write_data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_LW2   = 32'h8C020000;  // lw r2,0(r0)
    localparam logic [31:0] I_ADD   = 32'h00411820;  // add r3,r2,r1

    initial begin
        set_op(6'h00, 3'b010, 0, 1, 0, 0, 0, 0, 1, 2);
        set_op(6'h23, 3'b000, 1, 1, 1, 0, 0, 0, 0, 1);
        set_op(6'h2B, 3'b000, 1, 0, 0, 1, 0, 0, 1, 0);
        set_op(6'h04, 3'b001, 0, 0, 0, 0, 1, 0, 1, 0);
        set_op(6'h08, 3'b000, 1, 1, 0, 0, 0, 0, 0, 1);
        set_op(6'h0C, 3'b011, 1, 1, 0, 0, 0, 1, 0, 1);
        set_op(6'h0D, 3'b100, 1, 1, 0, 0, 0, 1, 0, 1);
        set_op(6'h0A, 3'b101, 1, 1, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        wb(0, 5'd0, 32'd0);
        drive(32'd0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        run = 1'b1;

        wb(1, 5'd1, 32'h00000011); tick();
        wb(1, 5'd2, 32'h00000022); tick();
        wb(1, 5'd7, 32'hAAAA0000); tick();
        wb(1, 5'd5, 32'h00000055); tick();
        wb(0, 5'd0, 32'd0);

        drive(32'h2005FFFF, 1, 0); tick();                   // addi r5,r0,-1
        chk("addi_imm", immediate, 32'hFFFFFFFF);
        chk("addi_src", {31'd0, alu_src}, 32'd1);
        chk("addi_aop", {29'd0, alu_op}, 32'd0);
        chk("addi_wreg", {27'd0, write_reg}, 32'd5);
        chk("addi_rw", {31'd0, reg_write}, 32'd1);

        drive(32'h3406FFFF, 1, 0); tick();                   // ori r6,r0,0xFFFF
        chk("ori_imm", immediate, 32'h0000FFFF);
        chk("ori_aop", {29'd0, alu_op}, 32'd4);

        drive(32'hFC000000, 1, 0); tick();                   // opcode 0x3F
        chk("illegal", {31'd0, illegal_instr}, 32'd1);
        chk("illegal_exv", {31'd0, ex_valid}, 32'd0);

        drive(I_LW2, 1, 0); tick();
        drive(I_ADD, 1, 0);
        chk("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_stall_drop", {31'd0, stall}, 32'd0);
        tick();
        chk("lu_add_exv", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_wreg", {27'd0, write_reg}, 32'd3);
        chk("lu_add_rd1", alu_read_data_1, 32'h00000022);
        chk("lu_add_rd2", alu_read_data_2, 32'h00000011);

        drive(I_LW2, 1, 0); tick();
        drive(I_ADD, 1, 1);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("flush_bubble", {31'd0, ex_valid}, 32'd0);

        drive(I_LW2, 1, 0); tick();
        drive(32'hAC220004, 1, 0);                           // sw r2,4(r1)
        chk("sw_rt_stall", {31'd0, stall}, 32'd1);
        tick(); tick();
        chk("sw_memw", {31'd0, mem_write}, 32'd1);
        chk("sw_rd2", alu_read_data_2, 32'h00000022);

        drive(I_LW2, 1, 0); tick();
        drive(32'h20020005, 1, 0);                           // addi r2,r0,5
        chk("addi_rt_nostall", {31'd0, stall}, 32'd0);
        tick();
        drive(I_LW2, 1, 0); tick();
        drive(I_ADD, 0, 0);
        chk("invalid_nostall", {31'd0, stall}, 32'd0);
        tick();
        drive(32'h8C000000, 1, 0); tick();                   // lw r0
        drive(32'h00004820, 1, 0);
        chk("lw_r0_nostall", {31'd0, stall}, 32'd0);
        tick();

        drive(32'h1022FFFE, 1, 0); tick();                   // beq r1,r2,-2
        chk("beq_imm", immediate, 32'hFFFFFFFE);
        chk("beq_br", {31'd0, branch}, 32'd1);
        drive(32'h3023F0F0, 1, 0); tick();                   // andi
        chk("andi_imm", immediate, 32'h0000F0F0);
        drive(32'h28248000, 1, 0); tick();                   // slti
        chk("slti_imm", immediate, 32'hFFFF8000);

        drive(32'h00E04020, 1, 0);                           // add r8,r7,r0
        wb(1, 5'd7, 32'h12345678); tick();
        chk("wb_same_cycle", alu_read_data_1, BYP ? 32'h12345678 : 32'hAAAA0000);
        wb(0, 5'd0, 32'd0); tick();
        chk("wb_next_cycle", alu_read_data_1, 32'h12345678);
        drive(32'h00004820, 1, 0);                           // add r9,r0,r0
        wb(1, 5'd0, 32'hDEADBEEF); tick();
        chk("r0_same", alu_read_data_1, 32'd0);
        wb(0, 5'd0, 32'd0); tick();
        chk("r0_after", alu_read_data_2, 32'd0);

        drive(I_LW2, 1, 0); tick();
        drive(I_ADD, 1, 0);
        chk("rst_pre_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_stall", {31'd0, stall}, 32'd0);
        chk("rst_async_memr", {31'd0, mem_read}, 32'd0);
        chk("rst_async_wreg", {27'd0, write_reg}, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        drive(32'h00A01820, 1, 0); tick();                   // add r3,r5,r0
        chk("rst_r5", alu_read_data_1, 32'd0);

        drive(32'd0, 0, 0); tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
